pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the hand-written per-stage latches between decode, execute and memory. It carries a generic payload, operand and destination register numbers, a tnew countdown for the hazard unit, and exception/delay-slot attributes. It resolves flush, hold and bubble requests with fixed priority. Each stage boundary instantiates one copy with its own widths.

## Interface
Parameters:
- PAYLOAD_W, 64, width of opaque control/data payload (decoded bus, immediates, operands)
- TNEW_W, 3, width of tnew countdown
- EXC_W, 5, width of exception code
- BUBBLE_PC, 32'hFFFF_FFFF, pc value presented while stage holds a bubble
- HOLD_DECAY, 0, 1 = tnew keeps decrementing while stage is held

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  exception/eret commit flush of this stage
- hold  in  1  downstream stall; keep current contents
- bubble  in  1  upstream stall; load a NOP instead of input
- in_valid  in  1  input slot carries a real instruction
- in_pc  in  32  instruction address
- in_payload  in  PAYLOAD_W  opaque payload
- in_a1, in_a2, in_a3  in  5  source/destination register numbers
- in_regwrite  in  1  instruction writes GPR
- in_tnew  in  TNEW_W  cycles until result available, measured at input stage
- in_exc_valid  in  1  exception already detected upstream
- in_exc_code  in  EXC_W  exception code
- in_bd  in  1  instruction is in a branch delay slot
- out_valid, out_pc, out_payload, out_a1, out_a2, out_a3, out_regwrite, out_tnew, out_exc_valid, out_exc_code, out_bd  out  widths as inputs  registered copies
- out_fwd_rdy  out  1  out_valid & out_regwrite & (out_tnew==0) & (out_a3!=0)

## Operation
- Per-cycle update, priority reset > flush > hold > bubble > load.
- reset or flush: clear slot (all outputs 0, out_pc=BUBBLE_PC, out_fwd_rdy=0).
- hold: all fields keep value; if HOLD_DECAY=1, out_tnew saturating-decrements.
- bubble (no hold): same clear as flush; counted separately.
- load: register inputs; out_tnew = in_tnew==0 ? 0 : in_tnew-1 (saturating, never wraps).
- in_valid=0 on load: treated as bubble (cleared slot), regardless of other inputs.
- in_exc_valid=1 on load: pc, code, bd, payload captured; out_regwrite and out_a3 forced 0 so no forwarding or writeback.
- out_fwd_rdy is combinational from registered state only.

## Timing
- Latency 1 cycle input to output; no combinational input-to-output path.
- Reset values: out_valid 0, out_pc BUBBLE_PC, every other output 0.
- flush and hold same cycle: flush wins, slot cleared.
- hold and bubble same cycle: hold wins, bubble request dropped (upstream must re-assert).
- Reset mid-hold: slot cleared next edge; hold ignored.
- tnew width: arithmetic in TNEW_W bits, saturation at 0.

## Configuration
- PIPE_STAGE_PERF_EN defined: three 32-bit wrapping counters hold_cnt, bubble_cnt, flush_cnt, output ports of same names; increment on each cycle where that action is the winning priority (reset not counted); cleared by reset.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Shared package pipe_pkg: BUBBLE_PC default, TNEW_W default, EXC_W, exception codes (EXC_ADEL=4, EXC_RI=10, EXC_OV=12), action encoding enum {ACT_RESET, ACT_FLUSH, ACT_HOLD, ACT_BUBBLE, ACT_LOAD}.
- One sub-module: pipe_perf_cnt (action in, three counters out), instantiated only under PIPE_STAGE_PERF_EN.

## Test plan
- Load in_valid=1, in_pc=0x3000, in_tnew=2, in_regwrite=1, in_a3=8 -> next cycle out_pc=0x3000, out_tnew=1, out_fwd_rdy=0; in_tnew=0 -> out_tnew=0, out_fwd_rdy=1.
- hold=1 for 3 cycles with HOLD_DECAY=0 -> outputs frozen; HOLD_DECAY=1, out_tnew=2 -> 1,0,0.
- flush=1 together with hold=1 -> out_valid=0, out_pc=0xFFFF_FFFF; hold_cnt unchanged, flush_cnt+1.
- Load in_exc_valid=1, code=10, in_bd=1, in_regwrite=1, in_a3=5 -> out_exc_code=10, out_bd=1, out_regwrite=0, out_a3=0.
- bubble=1 with valid input -> cleared slot; bubble+hold -> contents kept, bubble_cnt unchanged.
- Assert reset during hold sequence -> all outputs reset values next edge; counters (PERF_EN) zero.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers: defaults,
// exception codes and the per-cycle action encoding.
package pipe_pkg;

    localparam int unsigned PC_W       = 32;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned TNEW_W_DEF = 3;
    localparam int unsigned EXC_W_DEF  = 5;
    localparam int unsigned CNT_W      = 32;

    localparam logic [PC_W-1:0] BUBBLE_PC_DEF = 32'hFFFF_FFFF;

    localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

    // Winning request for one cycle, highest priority first
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } act_e;

    // Fixed-width slot attributes common to every stage boundary
    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        logic [REG_W-1:0] a1;
        logic [REG_W-1:0] a2;
        logic [REG_W-1:0] a3;
        logic             regwrite;
        logic             exc_valid;
        logic             bd;
    } stage_attr_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Slot bundle between two pipeline stages: input side from the upstream stage,
// registered output side towards the downstream stage.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned TNEW_W    = TNEW_W_DEF,
    parameter int unsigned EXC_W     = EXC_W_DEF
);

    logic                 in_valid;
    logic [PC_W-1:0]      in_pc;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [REG_W-1:0]     in_a1;
    logic [REG_W-1:0]     in_a2;
    logic [REG_W-1:0]     in_a3;
    logic                 in_regwrite;
    logic [TNEW_W-1:0]    in_tnew;
    logic                 in_exc_valid;
    logic [EXC_W-1:0]     in_exc_code;
    logic                 in_bd;

    logic                 out_valid;
    logic [PC_W-1:0]      out_pc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [REG_W-1:0]     out_a1;
    logic [REG_W-1:0]     out_a2;
    logic [REG_W-1:0]     out_a3;
    logic                 out_regwrite;
    logic [TNEW_W-1:0]    out_tnew;
    logic                 out_exc_valid;
    logic [EXC_W-1:0]     out_exc_code;
    logic                 out_bd;
    logic                 out_fwd_rdy;

    modport master (
        output in_valid, in_pc, in_payload, in_a1, in_a2, in_a3, in_regwrite,
               in_tnew, in_exc_valid, in_exc_code, in_bd,
        input  out_valid, out_pc, out_payload, out_a1, out_a2, out_a3, out_regwrite,
               out_tnew, out_exc_valid, out_exc_code, out_bd, out_fwd_rdy
    );

    modport slave (
        input  in_valid, in_pc, in_payload, in_a1, in_a2, in_a3, in_regwrite,
               in_tnew, in_exc_valid, in_exc_code, in_bd,
        output out_valid, out_pc, out_payload, out_a1, out_a2, out_a3, out_regwrite,
               out_tnew, out_exc_valid, out_exc_code, out_bd, out_fwd_rdy
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Hold/bubble/flush occupancy counters for one pipeline register; each counts
// cycles in which its action won the priority resolution.
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  act_e             act,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (act == ACT_HOLD)   hold_cnt   <= hold_cnt   + CNT_W'(1);
            if (act == ACT_BUBBLE) bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (act == ACT_FLUSH)  flush_cnt  <= flush_cnt  + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with reset > flush > hold > bubble > load.
// Define PIPE_STAGE_PERF_EN to add the hold_cnt/bubble_cnt/flush_cnt counter ports.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     PAYLOAD_W  = 64,
    parameter int unsigned     TNEW_W     = TNEW_W_DEF,
    parameter int unsigned     EXC_W      = EXC_W_DEF,
    parameter logic [PC_W-1:0] BUBBLE_PC  = BUBBLE_PC_DEF,
    parameter int unsigned     HOLD_DECAY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    pipe_stage_reg_if.slave  stg
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam stage_attr_t ATTR_CLR = '{
        valid: 1'b0, pc: BUBBLE_PC, a1: '0, a2: '0, a3: '0,
        regwrite: 1'b0, exc_valid: 1'b0, bd: 1'b0
    };

    act_e                 act;
    logic                 load_slot;
    stage_attr_t          attr_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [TNEW_W-1:0]    tnew_q;
    logic [EXC_W-1:0]     exc_code_q;
    logic [TNEW_W-1:0]    tnew_in_dec;
    logic [TNEW_W-1:0]    tnew_q_dec;

    always_comb begin
        act = ACT_LOAD;
        if (reset)       act = ACT_RESET;
        else if (flush)  act = ACT_FLUSH;
        else if (hold)   act = ACT_HOLD;
        else if (bubble) act = ACT_BUBBLE;
    end

    // An empty input slot on a load cycle is stored as a bubble
    assign load_slot   = (act == ACT_LOAD) && stg.in_valid;
    assign tnew_in_dec = (stg.in_tnew == '0) ? '0 : stg.in_tnew - TNEW_W'(1);
    assign tnew_q_dec  = (tnew_q == '0) ? '0 : tnew_q - TNEW_W'(1);

    always_ff @(posedge clk) begin
        if (act == ACT_HOLD) begin
            if (HOLD_DECAY != 0) tnew_q <= tnew_q_dec;
        end else if (load_slot) begin
            attr_q.valid     <= 1'b1;
            attr_q.pc        <= stg.in_pc;
            attr_q.a1        <= stg.in_a1;
            attr_q.a2        <= stg.in_a2;
            // A faulting instruction must never forward or write back
            attr_q.a3        <= stg.in_exc_valid ? '0 : stg.in_a3;
            attr_q.regwrite  <= stg.in_regwrite & ~stg.in_exc_valid;
            attr_q.exc_valid <= stg.in_exc_valid;
            attr_q.bd        <= stg.in_bd;
            payload_q        <= stg.in_payload;
            tnew_q           <= tnew_in_dec;
            exc_code_q       <= stg.in_exc_code;
        end else begin
            attr_q     <= ATTR_CLR;
            payload_q  <= '0;
            tnew_q     <= '0;
            exc_code_q <= '0;
        end
    end

    assign stg.out_valid     = attr_q.valid;
    assign stg.out_pc        = attr_q.pc;
    assign stg.out_payload   = payload_q;
    assign stg.out_a1        = attr_q.a1;
    assign stg.out_a2        = attr_q.a2;
    assign stg.out_a3        = attr_q.a3;
    assign stg.out_regwrite  = attr_q.regwrite;
    assign stg.out_tnew      = tnew_q;
    assign stg.out_exc_valid = attr_q.exc_valid;
    assign stg.out_exc_code  = exc_code_q;
    assign stg.out_bd        = attr_q.bd;
    assign stg.out_fwd_rdy   = attr_q.valid & attr_q.regwrite & (tnew_q == '0) & (attr_q.a3 != '0);

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt u_perf (
        .clk        (clk),
        .reset      (reset),
        .act        (act),
        .hold_cnt   (hold_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );
`endif

endmodule
